// File: rtl/clock_ctrl.sv
// clock_ctrl: HH:MM:SS timekeeping controller.
// It divides clk down to a 1 s tick and runs cascaded BCD seconds, minutes and
// hours fields. A run/set state machine, driven by the debounced mode_p and
// inc_p pulses, lets the user set the time one field at a time.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_RUN   | time advances on every prescaler tick; blink held high
// ST_SET_H | time frozen; inc_p steps hours; hours field blinks at 1 Hz
// ST_SET_M | time frozen; inc_p steps minutes
// ST_SET_S | time frozen; inc_p steps seconds; leaving restarts the prescaler
module clock_ctrl #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_p,
  input  logic       inc_p,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hour,
  output logic [1:0] state,
  output logic       blink,
  output logic       sec_tick,
  output logic       min_carry,
  output logic       day_p
);

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(TICK_DIV / 2);

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_H = 2'd1,
    ST_SET_M = 2'd2,
    ST_SET_S = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic [7:0]       sec_d;
  logic [7:0]       min_d;
  logic [7:0]       hour_d;
  logic             tick;
  logic             sec_wrap;
  logic             min_wrap;
  logic             hour_wrap;
  logic             set_inc;

  // One BCD step with wrap to 00 at the field's modulus. Anything at or above
  // the maximum also wraps, so a field can never run past its legal range.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] maxv);
    logic [7:0] r;
    if (v >= maxv) begin
      r = 8'h00;
    end else if (v[3:0] >= 4'd9) begin
      r = {v[7:4] + 4'd1, 4'h0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  assign tick      = (state_q == ST_RUN) && (div_q == DIV_LAST);
  assign sec_wrap  = (sec  == SEC_MAX);
  assign min_wrap  = (min  == MIN_MAX);
  assign hour_wrap = (hour == HOUR_MAX);
  // mode_p takes precedence over inc_p when both arrive together.
  assign set_inc   = inc_p && !mode_p;
  assign state     = state_q;

  // Next FSM state: mode_p walks RUN -> SET_H -> SET_M -> SET_S -> RUN.
  always_comb begin
    state_d = state_q;
    if (mode_p) begin
      case (state_q)
        ST_RUN:   state_d = ST_SET_H;
        ST_SET_H: state_d = ST_SET_M;
        ST_SET_M: state_d = ST_SET_S;
        ST_SET_S: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // Prescaler runs in every state; it restarts on leaving set mode so the
  // first tick lands a full TICK_DIV cycles after returning to RUN.
  always_comb begin
    if (state_q == ST_SET_S && mode_p) begin
      div_d = '0;
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  // Field updates: the whole sec->min->hour carry resolves in one edge in RUN;
  // in set mode only the selected field steps and nothing carries.
  always_comb begin
    sec_d  = sec;
    min_d  = min;
    hour_d = hour;
    if (tick) begin
      sec_d = bcd_inc(sec, SEC_MAX);
      if (sec_wrap) begin
        min_d = bcd_inc(min, MIN_MAX);
        if (min_wrap) begin
          hour_d = bcd_inc(hour, HOUR_MAX);
        end
      end
    end else if (set_inc) begin
      case (state_q)
        ST_SET_H: hour_d = bcd_inc(hour, HOUR_MAX);
        ST_SET_M: min_d  = bcd_inc(min, MIN_MAX);
        ST_SET_S: sec_d  = bcd_inc(sec, SEC_MAX);
        default:  ;
      endcase
    end
  end

  // Registered state, prescaler, time fields and output pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      div_q     <= '0;
      sec       <= 8'h00;
      min       <= 8'h00;
      hour      <= 8'h00;
      blink     <= 1'b1;
      sec_tick  <= 1'b0;
      min_carry <= 1'b0;
      day_p     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      sec       <= sec_d;
      min       <= min_d;
      hour      <= hour_d;
      // blink is computed from next-cycle state/div so it lines up with them.
      blink     <= (state_d == ST_RUN) || (div_d < DIV_HALF);
      sec_tick  <= tick;
      min_carry <= tick && sec_wrap;
      day_p     <= tick && sec_wrap && min_wrap && hour_wrap;
    end
  end

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl with TICK_DIV=4: a cycle-by-cycle vector
// table followed by hand-written multi-cycle sequences.
module tb_clock_ctrl;

  logic       clk;
  logic       reset;
  logic       mode_p;
  logic       inc_p;
  logic [7:0] sec;
  logic [7:0] min;
  logic [7:0] hour;
  logic [1:0] state;
  logic       blink;
  logic       sec_tick;
  logic       min_carry;
  logic       day_p;

  int tests;
  int fails;

  clock_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk),
    .reset(reset),
    .mode_p(mode_p),
    .inc_p(inc_p),
    .sec(sec),
    .min(min),
    .hour(hour),
    .state(state),
    .blink(blink),
    .sec_tick(sec_tick),
    .min_carry(min_carry),
    .day_p(day_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       mode;
    logic       inc;
    logic [1:0] st;
    logic [7:0] s;
    logic [7:0] m;
    logic [7:0] h;
    logic       bl;
    logic       tk;
    logic       mc;
    logic       dp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs for one edge, then sample just after it.
  task automatic step(input logic r, input logic m, input logic i);
    reset  = r;
    mode_p = m;
    inc_p  = i;
    @(posedge clk);
    #1;
    mode_p = 1'b0;
    inc_p  = 1'b0;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic bad_bcd(input logic [7:0] v, input logic [7:0] maxv);
    return (v[3:0] > 4'd9) || (v[7:4] > maxv[7:4]) || (v > maxv);
  endfunction

  initial begin
    int n_tick;
    int n_carry;
    int n_bad;
    int exp_div;
    logic [7:0] prev_sec;

    tests   = 0;
    fails   = 0;
    reset   = 1'b1;
    mode_p  = 1'b0;
    inc_p   = 1'b0;

    //              rst  md   ic   st     s      m      h      bl   tk   mc   dp
    vecs.push_back('{1'b1,1'b0,1'b0,2'd0,8'h00,8'h00,8'h00,1'b1,1'b0,1'b0,1'b0}); // 0 reset
    vecs.push_back('{1'b1,1'b0,1'b0,2'd0,8'h00,8'h00,8'h00,1'b1,1'b0,1'b0,1'b0}); // 1
    vecs.push_back('{1'b0,1'b0,1'b0,2'd0,8'h00,8'h00,8'h00,1'b1,1'b0,1'b0,1'b0}); // 2 div=1
    vecs.push_back('{1'b0,1'b0,1'b0,2'd0,8'h00,8'h00,8'h00,1'b1,1'b0,1'b0,1'b0}); // 3 div=2
    vecs.push_back('{1'b0,1'b0,1'b0,2'd0,8'h00,8'h00,8'h00,1'b1,1'b0,1'b0,1'b0}); // 4 div=3
    vecs.push_back('{1'b0,1'b0,1'b0,2'd0,8'h01,8'h00,8'h00,1'b1,1'b1,1'b0,1'b0}); // 5 first tick
    vecs.push_back('{1'b0,1'b0,1'b0,2'd0,8'h01,8'h00,8'h00,1'b1,1'b0,1'b0,1'b0}); // 6 div=1
    vecs.push_back('{1'b0,1'b1,1'b0,2'd1,8'h01,8'h00,8'h00,1'b0,1'b0,1'b0,1'b0}); // 7 SET_H div=2
    vecs.push_back('{1'b0,1'b0,1'b1,2'd1,8'h01,8'h00,8'h01,1'b0,1'b0,1'b0,1'b0}); // 8 div=3
    vecs.push_back('{1'b0,1'b0,1'b1,2'd1,8'h01,8'h00,8'h02,1'b1,1'b0,1'b0,1'b0}); // 9 div=0 no tick
    vecs.push_back('{1'b0,1'b0,1'b0,2'd1,8'h01,8'h00,8'h02,1'b1,1'b0,1'b0,1'b0}); // 10 div=1
    vecs.push_back('{1'b0,1'b1,1'b1,2'd2,8'h01,8'h00,8'h02,1'b0,1'b0,1'b0,1'b0}); // 11 mode wins
    vecs.push_back('{1'b0,1'b0,1'b1,2'd2,8'h01,8'h01,8'h02,1'b0,1'b0,1'b0,1'b0}); // 12 min++
    vecs.push_back('{1'b0,1'b1,1'b0,2'd3,8'h01,8'h01,8'h02,1'b1,1'b0,1'b0,1'b0}); // 13 SET_S div=0
    vecs.push_back('{1'b0,1'b0,1'b1,2'd3,8'h02,8'h01,8'h02,1'b1,1'b0,1'b0,1'b0}); // 14 sec++
    vecs.push_back('{1'b0,1'b1,1'b0,2'd0,8'h02,8'h01,8'h02,1'b1,1'b0,1'b0,1'b0}); // 15 RUN div forced 0
    vecs.push_back('{1'b0,1'b0,1'b0,2'd0,8'h02,8'h01,8'h02,1'b1,1'b0,1'b0,1'b0}); // 16
    vecs.push_back('{1'b0,1'b0,1'b0,2'd0,8'h02,8'h01,8'h02,1'b1,1'b0,1'b0,1'b0}); // 17
    vecs.push_back('{1'b0,1'b0,1'b0,2'd0,8'h02,8'h01,8'h02,1'b1,1'b0,1'b0,1'b0}); // 18
    vecs.push_back('{1'b0,1'b0,1'b0,2'd0,8'h03,8'h01,8'h02,1'b1,1'b1,1'b0,1'b0}); // 19 tick 4 after
    vecs.push_back('{1'b0,1'b0,1'b1,2'd0,8'h03,8'h01,8'h02,1'b1,1'b0,1'b0,1'b0}); // 20 inc in RUN
    vecs.push_back('{1'b0,1'b0,1'b0,2'd0,8'h03,8'h01,8'h02,1'b1,1'b0,1'b0,1'b0}); // 21
    vecs.push_back('{1'b0,1'b0,1'b0,2'd0,8'h03,8'h01,8'h02,1'b1,1'b0,1'b0,1'b0}); // 22
    vecs.push_back('{1'b0,1'b1,1'b0,2'd1,8'h04,8'h01,8'h02,1'b1,1'b1,1'b0,1'b0}); // 23 mode on tick
    vecs.push_back('{1'b0,1'b0,1'b0,2'd1,8'h04,8'h01,8'h02,1'b1,1'b0,1'b0,1'b0}); // 24 div=1
    vecs.push_back('{1'b0,1'b0,1'b0,2'd1,8'h04,8'h01,8'h02,1'b0,1'b0,1'b0,1'b0}); // 25 div=2
    vecs.push_back('{1'b1,1'b0,1'b0,2'd0,8'h00,8'h00,8'h00,1'b1,1'b0,1'b0,1'b0}); // 26 reset in set

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].mode, vecs[k].inc);
      check($sformatf("vec%0d", k),
            32'({state, sec, min, hour, blink, sec_tick, min_carry, day_p}),
            32'({vecs[k].st, vecs[k].s, vecs[k].m, vecs[k].h,
                 vecs[k].bl, vecs[k].tk, vecs[k].mc, vecs[k].dp}));
    end

    // Run 240 cycles: one full minute of ticks.
    do_reset();
    n_tick   = 0;
    n_carry  = 0;
    n_bad    = 0;
    prev_sec = 8'h00;
    for (int c = 0; c < 240; c++) begin
      step(1'b0, 1'b0, 1'b0);
      if (sec_tick) n_tick++;
      if (min_carry) n_carry++;
      if (bad_bcd(sec, 8'h59) || bad_bcd(min, 8'h59)) n_bad++;
      if (sec_tick && prev_sec[3:0] == 4'h9) begin
        check("run_units9_step", 32'(sec), 32'({prev_sec[7:4] + 4'd1, 4'h0} & 8'hff) % 32'h60);
      end
      prev_sec = sec;
    end
    check("run_sec", 32'(sec), 32'h00);
    check("run_min", 32'(min), 32'h01);
    check("run_ticks", n_tick, 60);
    check("run_carries", n_carry, 1);
    check("run_bad_bcd", n_bad, 0);

    // Set hour: 25 increments with a div/blink model running alongside.
    do_reset();
    exp_div = 0;
    n_tick  = 0;
    step(1'b0, 1'b1, 1'b0);
    exp_div = (exp_div + 1) % 4;
    check("seth_state", 32'(state), 32'd1);
    check("seth_blink0", 32'(blink), 32'(exp_div < 2));
    for (int k = 1; k <= 25; k++) begin
      step(1'b0, 1'b0, 1'b1);
      exp_div = (exp_div + 1) % 4;
      if (sec_tick) n_tick++;
      check($sformatf("seth_hour%0d", k), 32'(hour), 32'(to_bcd(k % 24)));
      check($sformatf("seth_blink%0d", k), 32'(blink), 32'(exp_div < 2));
    end
    check("seth_secmin", 32'({sec, min}), 32'h0000);
    check("seth_ticks", n_tick, 0);

    // Day wrap from 23:59:59.
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 23; k++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 59; k++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 59; k++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    check("day_preset", 32'({state, hour, min, sec}), 32'({2'd0, 24'h235959}));
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 1'b0, 1'b0);
      check($sformatf("day_wait%0d", k), 32'({hour, min, sec, sec_tick, min_carry, day_p}),
            32'({24'h235959, 3'b000}));
    end
    step(1'b0, 1'b0, 1'b0);
    check("day_wrap", 32'({hour, min, sec, sec_tick, min_carry, day_p}),
          32'({24'h000000, 3'b111}));
    step(1'b0, 1'b0, 1'b0);
    check("day_after", 32'({sec_tick, min_carry, day_p}), 32'b000);

    // Reset in the middle of SET_M, then confirm the prescaler restarted.
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 37; k++) step(1'b0, 1'b0, 1'b1);
    check("mid_min37", 32'({state, min}), 32'({2'd2, 8'h37}));
    step(1'b1, 1'b0, 1'b0);
    check("mid_reset", 32'({state, hour, min, sec, blink, sec_tick, min_carry, day_p}),
          32'({2'd0, 24'h000000, 4'b1000}));
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 1'b0, 1'b0);
      check($sformatf("mid_wait%0d", k), 32'({sec, sec_tick}), 32'({8'h00, 1'b0}));
    end
    step(1'b0, 1'b0, 1'b0);
    check("mid_tick", 32'({sec, sec_tick}), 32'({8'h01, 1'b1}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
